rf_write_arbiter: RTL

Arbitrates the general-purpose register file's single write port between two writeback sources: the in-order pipeline writeback stage (port A) and the multi-cycle mul/div unit (port B). Port B results are queued in a small FIFO, and the arbiter drives the register-file write interface from registered outputs. An optional starvation guard forces queued B results through when A streams continuously. The block sits between the WB stage / mul-div unit and the register file.

---
 rtl/rf_write_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline WB (A) vs queued mul/div results (B).
// Define RF_STARVE_GUARD_EN to force queued B results through when A streams.
module rf_write_arbiter #(
    parameter int B_DEPTH  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] a_pc,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    input  logic [31:0] b_pc,
    output logic        reg_write,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] write_pc,
    output logic [31:0] b_pend_mask
);
    localparam int PW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
    localparam int CW = $clog2(B_DEPTH + 1);

    if (B_DEPTH < 2 || (B_DEPTH & (B_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("B_DEPTH must be a power of two >= 2");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
        $error("MAX_WAIT must be in 1..15");
    end

    logic [4:0]         q_addr [B_DEPTH];
    logic [31:0]        q_data [B_DEPTH];
    logic [31:0]        q_pc   [B_DEPTH];
    logic [B_DEPTH-1:0] q_v;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      count;
    logic               empty;
    logic               push;
    logic               pop;
    logic               a_hs;
    logic               starve;

    assign empty   = (count == '0);
    assign b_ready = (count < CW'(B_DEPTH));
    assign push    = b_valid && b_ready;
    assign a_ready = !starve;
    assign a_hs    = a_valid && a_ready;
    // Starve forces a_ready low, so it also lands here as a pop.
    assign pop     = !a_hs && !empty;

`ifdef RF_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;

    assign starve = (wait_cnt == WAIT_LIM) && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (pop || empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Payload storage carries no reset; q_v alone says what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= b_addr;
            q_data[wr_ptr] <= b_data;
            q_pc[wr_ptr]   <= b_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            q_v    <= '0;
        end else begin
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                q_v[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr     <= wr_ptr + PW'(1);
                q_v[wr_ptr] <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            write_pc   <= '0;
        end else if (pop) begin
            reg_write  <= (q_addr[rd_ptr] != 5'd0);
            write_addr <= q_addr[rd_ptr];
            write_data <= q_data[rd_ptr];
            write_pc   <= q_pc[rd_ptr];
        end else if (a_hs) begin
            reg_write  <= (a_addr != 5'd0);
            write_addr <= a_addr;
            write_data <= a_data;
            write_pc   <= a_pc;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    always_comb begin
        b_pend_mask = '0;
        for (int i = 0; i < B_DEPTH; i++) begin
            if (q_v[i]) begin
                b_pend_mask[q_addr[i]] = 1'b1;
            end
        end
        b_pend_mask[0] = 1'b0;
    end

endmodule
